// File: rtl/alu_div.sv
// alu_div: sequential signed restoring divider, one quotient bit per clock, result {remainder, quotient}
module alu_div #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic [2*WIDTH-1:0] result
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2;
  localparam int CW = $clog2(WIDTH);
  logic [1:0]       state;
  logic [WIDTH-1:0] q, d, ax, ay;
  logic [WIDTH:0]   rem, sh, t;
  logic             sx, sq;
  logic [CW-1:0]    count;
  always_comb begin
    ax = x[WIDTH-1] ? -x : x;
    ay = y[WIDTH-1] ? -y : y;
    sh = {rem[WIDTH-1:0], q[WIDTH-1]};
    t  = sh - {1'b0, d};
  end
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      q        <= '0;
      d        <= '0;
      rem      <= '0;
      sx       <= 1'b0;
      sq       <= 1'b0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (y == '0) begin
            result   <= {x, {WIDTH{1'b1}}};
            div_zero <= 1'b1;
            done     <= 1'b1;
          end else begin
            q        <= ax;
            d        <= ay;
            rem      <= '0;
            sx       <= x[WIDTH-1];
            sq       <= x[WIDTH-1] ^ y[WIDTH-1];
            count    <= '0;
            busy     <= 1'b1;
            div_zero <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          // t[WIDTH] set means the trial subtraction went negative: restore
          rem   <= t[WIDTH] ? sh : t;
          q     <= {q[WIDTH-2:0], ~t[WIDTH]};
          count <= count + 1'b1;
          state <= (count == CW'(WIDTH - 1)) ? FIX : RUN;
        end
        FIX: begin
          result <= {sx ? -rem[WIDTH-1:0] : rem[WIDTH-1:0], sq ? -q : q};
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_div.sv
// tb_alu_div: table-driven vectors plus hand sequences for clear, restart-while-busy and back-to-back starts
module tb_alu_div;
  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [31:0] x = '0, y = '0;
  logic        busy, done, div_zero;
  logic [63:0] result;
  int compared = 0, mismatched = 0;

  alu_div #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .div_zero(div_zero), .result(result)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a, b, q, r;
    logic        dz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input logic dz, input logic chained, input int repulse);
    int n, busy_cnt;
    @(negedge clock);
    if (chained) chk({name, " no_gap_done"}, 64'(done), 64'd1);
    x = a;
    y = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    x = $urandom;
    y = $urandom;
    n = 0;
    busy_cnt = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      start = (n == repulse);
      if (start) begin
        x = 32'd1;
        y = 32'd1;
      end
      @(posedge clock);
      #1;
      n++;
      if (busy && done) chk({name, " done_with_busy"}, 64'(busy), 64'd0);
    end
    start = 1'b0;
    chk({name, " latency"}, 64'(n), dz ? 64'd0 : 64'd33);
    chk({name, " busy_cycles"}, 64'(busy_cnt), dz ? 64'd0 : 64'd33);
    chk({name, " result"}, result, exp);
    chk({name, " div_zero"}, 64'(div_zero), 64'(dz));
  endtask

  vec_t v[13];
  logic [63:0] held;
  int late;

  initial begin
    v[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    v[1]  = '{-32'sd100,      32'd7,          -32'sd14,       -32'sd2,        1'b0};
    v[2]  = '{32'd7,          -32'sd100,      32'd0,          32'd7,          1'b0};
    v[3]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    v[4]  = '{32'h80000000,   32'h80000000,   32'd1,          32'd0,          1'b0};
    v[5]  = '{32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0};
    v[6]  = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    v[7]  = '{-32'sd7,        -32'sd2,        32'd3,          -32'sd1,        1'b0};
    v[8]  = '{32'd12345,      32'hFFFFFFFF,   -32'sd12345,    32'd0,          1'b0};
    v[9]  = '{32'h7FFFFFFF,   32'h80000000,   32'd0,          32'h7FFFFFFF,   1'b0};
    v[10] = '{32'hFFFFFFFF,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1};
    v[11] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    v[12] = '{32'd1000000007, 32'd97,         32'd10309278,   32'd41,         1'b0};

    #12;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset div_zero", 64'(div_zero), 64'd0);
    chk("reset result", result, 64'd0);
    @(negedge clock);
    clear = 1'b0;

    for (int i = 0; i < 13; i++)
      run($sformatf("vec%0d", i), v[i].a, v[i].b, {v[i].r, v[i].q}, v[i].dz, 1'b0, -1);

    held = result;
    @(posedge clock);
    #1;
    chk("done_pulse_width", 64'(done), 64'd0);
    chk("result_held", result, held);

    // clear in the middle of 100/7 must kill the division without a done
    @(negedge clock);
    x = 32'd100;
    y = 32'd7;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #3;
    clear = 1'b1;
    #1;
    chk("clear busy", 64'(busy), 64'd0);
    chk("clear done", 64'(done), 64'd0);
    chk("clear result", result, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    late = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done || busy) late++;
    end
    chk("clear no_late_done", 64'(late), 64'd0);
    run("after_clear", 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b0, -1);

    run("repulse", 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1'b0, 5);
    run("chain", -32'sd100, -32'sd7, {-32'sd2, 32'd14}, 1'b0, 1'b1, -1);
    run("zero_then", 32'd9, 32'd0, {32'd9, 32'hFFFFFFFF}, 1'b1, 1'b0, -1);
    run("clears_dz", 32'd9, 32'd4, {32'd1, 32'd2}, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/alu_div.md
Name: alu_div

Overview:
- Sequential signed 32-bit integer divider: the inverse operation to the team's combinational Booth multiplier.
- Sits beside the multiplier in the ALU. Its 64-bit result feeds the HI/LO register pair in the same packing as the multiplier's product.
- Restoring shift-subtract algorithm, one quotient bit per clock, with a start/busy/done handshake so the control unit can stall on DIV.

Parameters:
- WIDTH, 32, operand width. Result is 2*WIDTH. All values below assume 32.

Ports:
- clock  in  1  system clock, rising-edge.
- clear  in  1  reset, asynchronous, active-high.
- start  in  1  request a division. Sampled only in IDLE.
- x  in  32  dividend, two's complement. Sampled on the start edge only.
- y  in  32  divisor, two's complement. Sampled on the start edge only.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse. Result is valid from this cycle onward.
- div_zero  out  1  high with done when y==0. Held until next accepted start.
- result  out  64  {remainder[31:0], quotient[31:0]}, i.e. HI=remainder, LO=quotient. Held until the next accepted start.

Behaviour:
- Reset: clear=1 forces state=IDLE, busy=0, done=0, div_zero=0, result=0, and clears all internal registers, immediately and asynchronously. Clear mid-operation aborts the division; no done is produced.
- States: IDLE, RUN, FIX.
- IDLE:
  - On a clock edge with start=1 and y!=0 (edge E0): latch |x| into the quotient shift register, latch |y|, zero the 33-bit partial remainder, record sx=x[31] and sq=x[31]^y[31], set count=0, busy=1, go to RUN.
  - On start=1 with y==0 (divide by zero): do not enter RUN. At E0, set result={x, 32'hFFFFFFFF}, div_zero=1, done=1. Stay IDLE, busy stays 0.
  - An accepted start clears div_zero and any previous result flag; result retains its old value until overwritten.
- RUN, one step per edge:
  - Shift {rem, q} left 1.
  - Trial subtract t = rem - |y| at 33 bits.
  - If t is non-negative: rem=t, q[0]=1. Otherwise rem is unchanged and q[0]=0.
  - count increments. The step at count==31 (edge E32) moves to FIX.
- FIX (edge E33):
  - quotient = sq ? -q : q.
  - remainder = sx ? -rem : rem.
  - Load result, pulse done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: done is high in the cycle after E33 (33 clocks after the start edge). busy is high from E0 through E33, 33 cycles.
- Arithmetic semantics:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend, or is 0.
  - x == q*y + r always holds.
- Boundary conditions:
  - |x|<|y|: quotient 0, remainder x.
  - Magnitudes are computed in 32-bit unsigned, so |0x80000000| = 0x80000000 is handled naturally.
  - 0x80000000 / -1: quotient 0x80000000 (wraps), remainder 0. No special flag.
  - 0x80000000 / 1: quotient 0x80000000, remainder 0.
- start while busy: ignored. x and y may change freely during RUN/FIX without effect.
- start asserted in the same cycle done is high: accepted, because the FSM is in IDLE. The result stays visible until the new FIX edge.
- done is never high while busy=1.

Test Plan:
- clear=1 mid-RUN (e.g. at cycle 10 of 100/7) -> busy=0, done=0, result=0 immediately. No later done. A fresh start works normally.
- x=100, y=7, start 1 cycle -> busy for 33 cycles, done pulse at cycle 33, result={32'd2, 32'd14}.
- x=-100, y=7 -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2). Then x=7, y=-100 -> quotient 0, remainder 7.
- x=0x80000000, y=-1 -> quotient 0x80000000, remainder 0, div_zero=0. Then x=0x80000000, y=0x80000000 -> quotient 1, remainder 0.
- x=5, y=0 -> done and div_zero high in the cycle after the start edge, busy never asserts, result={32'd5, 32'hFFFFFFFF}. The next valid start clears div_zero.
- start re-pulsed with different operands during RUN -> ignored, original result delivered at cycle 33. A start in the done cycle launches the next division with no idle gap.
